// File: rtl/regs_salida_pkg.sv
// ---------------------------------------------------------------------------
// regs_salida_pkg
//
// Shared constants for the PicoBlaze output-register bank.
// Holds the relative port offsets of each register group (measured from
// PORT_BASE) and the data code that sets a control flag.
//
//   OFS_CTRL                    : offset of control flag 0
//   OFS_DATA(n_ctrl)            : offset of staging register 0
//   OFS_COMMIT(n_ctrl, n_data)  : offset of the COMMIT port
//   OFS_OVRCLR(n_ctrl, n_data)  : offset of the overrun-clear port
//   CTRL_SET                    : out_port value that sets a flag
// ---------------------------------------------------------------------------
package regs_salida_pkg;

    localparam int         OFS_CTRL = 0;
    localparam logic [7:0] CTRL_SET = 8'h01;

    // Staging registers follow directly after the flags.
    function automatic int OFS_DATA(input int n_ctrl);
        return OFS_CTRL + n_ctrl;
    endfunction

    // COMMIT sits right after the last staging register.
    function automatic int OFS_COMMIT(input int n_ctrl, input int n_data);
        return OFS_DATA(n_ctrl) + n_data;
    endfunction

    // Overrun-clear is the last port of the map.
    function automatic int OFS_OVRCLR(input int n_ctrl, input int n_data);
        return OFS_COMMIT(n_ctrl, n_data) + 1;
    endfunction

endpackage

// File: rtl/flag_ctrl_cell.sv
// ---------------------------------------------------------------------------
// flag_ctrl_cell
//
// One control flag together with its sticky overrun bit.
//
// Parameters:
//   PULSE     : 1 = self-clearing flag (high one cycle per set write),
//               0 = level flag (holds until cleared).
// Ports:
//   clk       in  : clock, rising edge
//   rst_n     in  : synchronous active-low reset
//   set_wr    in  : decoded write of the set code to this flag
//   clr_wr    in  : decoded write of any other code to this flag
//   clr_ctrl  in  : clear request from the controller FSM (highest priority
//                   after reset)
//   ovr_clr   in  : clear request for the overrun bit
//   flag      out : registered flag
//   ovr       out : registered sticky overrun bit
// ---------------------------------------------------------------------------
module flag_ctrl_cell
    import regs_salida_pkg::*;
#(
    parameter bit PULSE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_wr,
    input  logic clr_wr,
    input  logic clr_ctrl,
    input  logic ovr_clr,
    output logic flag,
    output logic ovr
);

    logic flag_reg;
    logic flag_next;
    logic ovr_reg;
    logic ovr_next;
    logic ovr_event;

    // A set while the flag is still pending means the controller has not
    // consumed the previous request. A pulse flag is only ever high in the
    // cycle right after its own set, so a set seen then is a back-to-back
    // request, which is legitimate and not treated as an overrun.
    assign ovr_event = set_wr && flag_reg && !clr_ctrl && !PULSE;

    always_comb begin
        flag_next = flag_reg;
        if (clr_ctrl) begin
            flag_next = 1'b0;
        end else if (set_wr) begin
            flag_next = 1'b1;
        end else if (clr_wr) begin
            flag_next = 1'b0;
        end else if (PULSE) begin
            flag_next = 1'b0;
        end
    end

    // A fresh overrun event beats a simultaneous clear of the same bit.
    always_comb begin
        ovr_next = ovr_reg;
        if (ovr_event) begin
            ovr_next = 1'b1;
        end else if (ovr_clr) begin
            ovr_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_reg <= 1'b0;
            ovr_reg  <= 1'b0;
        end else begin
            flag_reg <= flag_next;
            ovr_reg  <= ovr_next;
        end
    end

    assign flag = flag_reg;
    assign ovr  = ovr_reg;

endmodule

// File: rtl/registros_salida_param.sv
// ---------------------------------------------------------------------------
// registros_salida_param
//
// Parametrised output-register bank on the PicoBlaze output bus.
// Port map (offsets from PORT_BASE):
//   0 .. N_CTRL-1               control flags
//   N_CTRL .. N_CTRL+N_DATA-1   staging registers
//   N_CTRL+N_DATA               COMMIT (staging -> data_out, commit_valid)
//   N_CTRL+N_DATA+1             OVR_CLR (clear overrun bits by mask)
// Anything else, including port_id below PORT_BASE, is ignored.
//
// Ports:
//   clk           in  : clock, rising edge
//   rst_n         in  : synchronous active-low reset
//   write_strobe  in  : processor OUTPUT strobe
//   port_id       in  : port address
//   out_port      in  : write data
//   clr_ctrl      in  : per-flag clear from the controller FSM
//   ctrl_flags    out : control flags
//   data_out      out : published data, register k at [k*DW +: DW]
//   commit_valid  out : one-cycle pulse when data_out has just updated
//   overrun       out : sticky per-flag overrun
// All outputs are registered.
// ---------------------------------------------------------------------------
module registros_salida_param
    import regs_salida_pkg::*;
#(
    parameter logic [7:0]        PORT_BASE  = 8'h01,
    parameter int                N_CTRL     = 3,
    parameter int                N_DATA     = 2,
    parameter int                DW         = 8,
    parameter logic [N_CTRL-1:0] PULSE_MASK = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   write_strobe,
    input  logic [7:0]             port_id,
    input  logic [7:0]             out_port,
    input  logic [N_CTRL-1:0]      clr_ctrl,
    output logic [N_CTRL-1:0]      ctrl_flags,
    output logic [N_DATA*DW-1:0]   data_out,
    output logic                   commit_valid,
    output logic [N_CTRL-1:0]      overrun
);

    localparam logic [7:0] A_DATA   = 8'(OFS_DATA(N_CTRL));
    localparam logic [7:0] A_COMMIT = 8'(OFS_COMMIT(N_CTRL, N_DATA));
    localparam logic [7:0] A_OVRCLR = 8'(OFS_OVRCLR(N_CTRL, N_DATA));

    // -----------------------------------------------------------------
    // Address decoder
    // -----------------------------------------------------------------
    logic [7:0] addr_ofs;
    logic       wr_en;
    logic       is_set_code;
    logic       commit_hit;
    logic       ovr_clr_hit;

    // The subtraction wraps for port_id < PORT_BASE, so the range check
    // is what keeps such writes from aliasing onto high offsets.
    assign addr_ofs    = port_id - PORT_BASE;
    assign wr_en       = write_strobe && (port_id >= PORT_BASE);
    assign is_set_code = (out_port == CTRL_SET);
    assign commit_hit  = wr_en && (addr_ofs == A_COMMIT);
    assign ovr_clr_hit = wr_en && (addr_ofs == A_OVRCLR);

    // -----------------------------------------------------------------
    // Control flags with overrun detection
    // -----------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_CTRL; gi++) begin : g_flag
            logic ctrl_hit;

            assign ctrl_hit = wr_en && (addr_ofs == 8'(OFS_CTRL + gi));

            flag_ctrl_cell #(
                .PULSE (PULSE_MASK[gi])
            ) u_cell (
                .clk      (clk),
                .rst_n    (rst_n),
                .set_wr   (ctrl_hit && is_set_code),
                .clr_wr   (ctrl_hit && !is_set_code),
                .clr_ctrl (clr_ctrl[gi]),
                .ovr_clr  (ovr_clr_hit && out_port[gi]),
                .flag     (ctrl_flags[gi]),
                .ovr      (overrun[gi])
            );
        end
    endgenerate

    // -----------------------------------------------------------------
    // Staging and active (published) data registers
    // -----------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_DATA; gi++) begin : g_data
            logic          data_hit;
            logic [DW-1:0] staging_reg;
            logic [DW-1:0] active_reg;

            assign data_hit = wr_en && (addr_ofs == (A_DATA + 8'(gi)));

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    staging_reg <= '0;
                end else if (data_hit) begin
                    staging_reg <= out_port[DW-1:0];
                end
            end

            // Every active register loads on the same COMMIT edge, so the
            // downstream datapath never sees a half-updated word. Staging
            // is left intact so a repeated COMMIT republishes it.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    active_reg <= '0;
                end else if (commit_hit) begin
                    active_reg <= staging_reg;
                end
            end

            assign data_out[gi*DW +: DW] = active_reg;
        end
    endgenerate

    // -----------------------------------------------------------------
    // Commit pulse: high in exactly the cycle new data_out first shows.
    // -----------------------------------------------------------------
    logic commit_valid_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            commit_valid_reg <= 1'b0;
        end else begin
            commit_valid_reg <= commit_hit;
        end
    end

    assign commit_valid = commit_valid_reg;

endmodule

// File: tb/tb_registros_salida_param.sv
// ---------------------------------------------------------------------------
// tb_registros_salida_param
//
// Bench for registros_salida_param with PORT_BASE=8'h01, N_CTRL=3,
// N_DATA=2, DW=8, PULSE_MASK=3'b010.
// Port map: flags 01..03, staging 04..05, COMMIT 06, OVR_CLR 07.
// ---------------------------------------------------------------------------
module tb_registros_salida_param;

    localparam logic [2:0] PM = 3'b010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        write_strobe;
    logic [7:0]  port_id;
    logic [7:0]  out_port;
    logic [2:0]  clr_ctrl;
    logic [2:0]  ctrl_flags;
    logic [15:0] data_out;
    logic        commit_valid;
    logic [2:0]  overrun;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    registros_salida_param #(
        .PORT_BASE  (8'h01),
        .N_CTRL     (3),
        .N_DATA     (2),
        .DW         (8),
        .PULSE_MASK (PM)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_strobe (write_strobe),
        .port_id      (port_id),
        .out_port     (out_port),
        .clr_ctrl     (clr_ctrl),
        .ctrl_flags   (ctrl_flags),
        .data_out     (data_out),
        .commit_valid (commit_valid),
        .overrun      (overrun)
    );

    // ---------------------------------------------------------------
    // Reference model: register map behaviour stated as rules
    // ---------------------------------------------------------------
    logic [2:0] m_flag;
    logic [2:0] m_ovr;
    logic [7:0] m_stg [2];
    logic [7:0] m_act [2];
    logic       m_cv;

    task automatic model_step(input logic r, input logic w, input logic [7:0] p,
                              input logic [7:0] d, input logic [2:0] c);
        int         a;
        bit         hit;
        bit         set_w;
        bit         clr_w;
        logic [2:0] nf;
        logic [2:0] no;
        if (!r) begin
            m_flag = '0; m_ovr = '0; m_cv = 1'b0;
            m_stg[0] = '0; m_stg[1] = '0; m_act[0] = '0; m_act[1] = '0;
            return;
        end
        a   = int'(p) - 1;
        hit = w && (a >= 0) && (a <= 6);
        nf  = m_flag;
        no  = m_ovr;
        for (int i = 0; i < 3; i++) begin
            set_w = hit && (a == i) && (d == 8'h01);
            clr_w = hit && (a == i) && (d != 8'h01);
            if (c[i])           nf[i] = 1'b0;
            else if (set_w)     nf[i] = 1'b1;
            else if (clr_w)     nf[i] = 1'b0;
            else if (PM[i])     nf[i] = 1'b0;
            if (set_w && m_flag[i] && !c[i] && !PM[i]) no[i] = 1'b1;
            else if (hit && (a == 6) && d[i])          no[i] = 1'b0;
        end
        m_cv = 1'b0;
        if (hit && (a == 5)) begin
            m_act[0] = m_stg[0];
            m_act[1] = m_stg[1];
            m_cv     = 1'b1;
        end
        if (hit && (a == 3)) m_stg[0] = d;
        if (hit && (a == 4)) m_stg[1] = d;
        m_flag = nf;
        m_ovr  = no;
    endtask

    // Drive one cycle, advance the model on the same edge, sample 1 ns later.
    task automatic cycle(input logic r, input logic w, input logic [7:0] p,
                         input logic [7:0] d, input logic [2:0] c);
        rst_n        = r;
        write_strobe = w;
        port_id      = p;
        out_port     = d;
        clr_ctrl     = c;
        @(posedge clk);
        model_step(r, w, p, d, c);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------
    // Directed vector table: inputs and expected outputs after the edge
    // ---------------------------------------------------------------
    typedef struct {
        logic        r;
        logic        w;
        logic [7:0]  p;
        logic [7:0]  d;
        logic [2:0]  c;
        logic [2:0]  e_flags;
        logic [2:0]  e_ovr;
        logic [15:0] e_data;
        logic        e_cv;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    initial begin
        int hi_cnt;

        tbl[0]  = '{1'b0, 1'b0, 8'h00, 8'h00, 3'b000, 3'b000, 3'b000, 16'h0000, 1'b0}; // reset
        tbl[1]  = '{1'b1, 1'b1, 8'h01, 8'h01, 3'b000, 3'b001, 3'b000, 16'h0000, 1'b0}; // set f0
        tbl[2]  = '{1'b1, 1'b1, 8'h01, 8'h00, 3'b000, 3'b000, 3'b000, 16'h0000, 1'b0}; // clear f0
        tbl[3]  = '{1'b1, 1'b1, 8'h02, 8'h01, 3'b010, 3'b000, 3'b000, 16'h0000, 1'b0}; // set+clr f1
        tbl[4]  = '{1'b1, 1'b1, 8'h03, 8'h01, 3'b000, 3'b100, 3'b000, 16'h0000, 1'b0}; // set f2
        tbl[5]  = '{1'b1, 1'b1, 8'h03, 8'h01, 3'b000, 3'b100, 3'b100, 16'h0000, 1'b0}; // overrun
        tbl[6]  = '{1'b1, 1'b1, 8'h07, 8'h04, 3'b000, 3'b100, 3'b000, 16'h0000, 1'b0}; // ovr clr
        tbl[7]  = '{1'b1, 1'b1, 8'h02, 8'h01, 3'b000, 3'b110, 3'b000, 16'h0000, 1'b0}; // pulse f1
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 8'h00, 3'b000, 3'b100, 3'b000, 16'h0000, 1'b0}; // pulse ends
        tbl[9]  = '{1'b1, 1'b1, 8'h04, 8'hA5, 3'b000, 3'b100, 3'b000, 16'h0000, 1'b0}; // stage 0
        tbl[10] = '{1'b1, 1'b1, 8'h05, 8'h3C, 3'b000, 3'b100, 3'b000, 16'h0000, 1'b0}; // stage 1
        tbl[11] = '{1'b1, 1'b1, 8'h06, 8'h00, 3'b000, 3'b100, 3'b000, 16'h3CA5, 1'b1}; // commit
        tbl[12] = '{1'b1, 1'b0, 8'h00, 8'h00, 3'b000, 3'b100, 3'b000, 16'h3CA5, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 8'h06, 8'h55, 3'b000, 3'b100, 3'b000, 16'h3CA5, 1'b1}; // republish
        tbl[14] = '{1'b1, 1'b1, 8'h06, 8'h00, 3'b000, 3'b100, 3'b000, 16'h3CA5, 1'b1}; // b2b commit
        tbl[15] = '{1'b1, 1'b1, 8'h04, 8'h11, 3'b000, 3'b100, 3'b000, 16'h3CA5, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 8'h05, 8'h22, 3'b000, 3'b100, 3'b000, 16'h3CA5, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 8'h06, 8'h00, 3'b000, 3'b000, 3'b000, 16'h0000, 1'b0}; // reset drops commit
        tbl[18] = '{1'b1, 1'b1, 8'h06, 8'h00, 3'b000, 3'b000, 3'b000, 16'h0000, 1'b1}; // staging lost
        tbl[19] = '{1'b1, 1'b1, 8'h00, 8'h01, 3'b000, 3'b000, 3'b000, 16'h0000, 1'b0}; // below base
        tbl[20] = '{1'b1, 1'b1, 8'h08, 8'hFF, 3'b000, 3'b000, 3'b000, 16'h0000, 1'b0}; // above map
        tbl[21] = '{1'b1, 1'b1, 8'h01, 8'h01, 3'b000, 3'b001, 3'b000, 16'h0000, 1'b0};
        tbl[22] = '{1'b1, 1'b0, 8'h01, 8'h01, 3'b001, 3'b000, 3'b000, 16'h0000, 1'b0}; // clr no strobe
        tbl[23] = '{1'b1, 1'b1, 8'h02, 8'h01, 3'b000, 3'b010, 3'b000, 16'h0000, 1'b0};
        tbl[24] = '{1'b1, 1'b1, 8'h02, 8'h01, 3'b000, 3'b010, 3'b000, 16'h0000, 1'b0}; // b2b pulse
        tbl[25] = '{1'b1, 1'b0, 8'h00, 8'h00, 3'b000, 3'b000, 3'b000, 16'h0000, 1'b0};
        tbl[26] = '{1'b1, 1'b1, 8'h03, 8'h07, 3'b000, 3'b000, 3'b000, 16'h0000, 1'b0}; // non-01 code clears

        rst_n = 1'b0; write_strobe = 1'b0; port_id = '0; out_port = '0; clr_ctrl = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int v = 0; v < NV; v++) begin
            cycle(tbl[v].r, tbl[v].w, tbl[v].p, tbl[v].d, tbl[v].c);
            check($sformatf("vec%0d_flags", v), 32'(ctrl_flags),   32'(tbl[v].e_flags));
            check($sformatf("vec%0d_ovr",   v), 32'(overrun),      32'(tbl[v].e_ovr));
            check($sformatf("vec%0d_data",  v), 32'(data_out),     32'(tbl[v].e_data));
            check($sformatf("vec%0d_cv",    v), 32'(commit_valid), 32'(tbl[v].e_cv));
            $display("vec %0d: p=%h d=%h flags=%b ovr=%b data=%h cv=%b",
                     v, tbl[v].p, tbl[v].d, ctrl_flags, overrun, data_out, commit_valid);
        end

        // Pulse flag width: one set write gives exactly one high cycle.
        hi_cnt = 0;
        cycle(1'b1, 1'b1, 8'h02, 8'h01, 3'b000);
        if (ctrl_flags[1]) hi_cnt++;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b0, 8'h00, 8'h00, 3'b000);
            if (ctrl_flags[1]) hi_cnt++;
        end
        check("pulse_width", 32'(hi_cnt), 32'd1);
        $display("pulse_width high_cycles=%0d", hi_cnt);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic       r;
            logic       w;
            logic [7:0] p;
            logic [7:0] d;
            logic [2:0] c;
            r = ($urandom_range(0, 39) != 0);
            w = ($urandom_range(0, 3) != 0);
            p = 8'($urandom_range(0, 9));
            d = ($urandom_range(0, 1) != 0) ? 8'h01 : 8'($urandom);
            for (int b = 0; b < 3; b++) c[b] = ($urandom_range(0, 7) == 0);
            cycle(r, w, p, d, c);
            check($sformatf("rand%0d", n),
                  {12'd0, ctrl_flags, overrun, data_out, commit_valid},
                  {12'd0, m_flag, m_ovr, m_act[1], m_act[0], m_cv});
            $display("rand %0d: r=%b w=%b p=%h d=%h c=%b flags=%b ovr=%b data=%h cv=%b",
                     n, r, w, p, d, c, ctrl_flags, overrun, data_out, commit_valid);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
